// File: rtl/spike_bin_fifo_pkg.sv
// Shared constants and types for the spike binning FIFO.
//   WORD_W / HALF_W : FIFO word width and host half-word width
//   BIN_CNT_W / BIN_TS_W : default count / timestamp field widths (sum = WORD_W)
//   CNT_MAX         : saturation value of a default-width bin count
//   bin_word_t      : {ts, cnt} layout of one queued bin word
//   half_of()       : selects the low (hi=0) or high (hi=1) half of a word
package spike_bin_pkg;
  localparam int WORD_W    = 32;
  localparam int HALF_W    = 16;
  localparam int BIN_CNT_W = 16;
  localparam int BIN_TS_W  = 16;
  localparam logic [BIN_CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [BIN_TS_W-1:0]  ts;
    logic [BIN_CNT_W-1:0] cnt;
  } bin_word_t;

  function automatic logic [HALF_W-1:0] half_of(input logic [WORD_W-1:0] w, input logic hi);
    return hi ? w[WORD_W-1:HALF_W] : w[HALF_W-1:0];
  endfunction
endpackage

// File: rtl/spike_bin_fifo_if.sv
// Host pipe-out link of the spike binning FIFO.
//   pipe_read : one-cycle strobe per half-word consumed by the host
//   pipe_data : half-word currently presented to the host
// master = host side, slave = FIFO side.
interface spike_bin_fifo_if;
  import spike_bin_pkg::*;
  logic              pipe_read;
  logic [HALF_W-1:0] pipe_data;

  modport master (output pipe_read, input pipe_data);
  modport slave  (input pipe_read, output pipe_data);
endinterface

// File: rtl/spike_bin_fifo_sync_fifo_32.sv
// sync_fifo_32: single-clock 32-bit FIFO on an inferred block RAM.
// Ports: clk, reset_n (async active-low), clr (sync flush), wr_en/wr_data,
//   rd_en (pop), rd_data (registered head word), full, empty, level.
// rd_data always holds the current head: the read address looks one entry
// ahead while popping, and a write landing on the address being read is
// forwarded so a word written into an (about to be) empty FIFO is visible
// right after the write edge. The caller must never push when full without
// popping, nor pop when empty.
module sync_fifo_32
  import spike_bin_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]     wr_addr, rd_addr;
  logic [WORD_W-1:0] rd_data_reg;

  assign wr_addr = wr_ptr_reg[AW-1:0];
  assign rd_addr = rd_en ? rd_ptr_reg[AW-1:0] + 1'b1 : rd_ptr_reg[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else if (clr) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      rd_data_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && (wr_addr == rd_addr)) rd_data_reg <= wr_data;
      else                               rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (level == (AW+1)'(DEPTH));
endmodule

// File: rtl/spike_bin_fifo.sv
// spike_bin_fifo: counts spike pulses per 1 ms bin (bin edge = sim_clk rise),
// stamps each bin with a wrapping timestamp and queues {ts, count} words for
// the host, which drains them low half first through the pipe interface.
// Ports: clk, reset_n (async active-low), spike_in / sim_clk_in (async
//   levels), enable, clear (sync flush), pipe (slave: pipe_read, pipe_data),
//   fifo_level, empty, full, overflow (sticky drop), underflow (sticky read
//   while empty), ts_now (timestamp of the open bin).
// Build option: SPIKE_BIN_SKIP_EMPTY_EN -- zero-count bins are not queued
//   (the timestamp still advances).
module spike_bin_fifo
  import spike_bin_pkg::*;
#(
  parameter  int DEPTH = 1024,
  parameter  int CNT_W = BIN_CNT_W,
  parameter  int TS_W  = BIN_TS_W,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spike_in,
  input  logic             sim_clk_in,
  input  logic             enable,
  input  logic             clear,
  spike_bin_fifo_if.slave  pipe,
  output logic [LVL_W-1:0] fifo_level,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  output logic [TS_W-1:0]  ts_now
);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  // Bit 0 = spike, bit 1 = sim clock: two sync flops, then an edge register.
  logic [1:0] raw_in, pulse;
  assign raw_in = {sim_clk_in, spike_in};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg, sync_reg, prev_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end
      assign pulse[gi] = sync_reg & ~prev_reg;
    end
  endgenerate

  logic              spike_pulse, sim_pulse, bin_wanted, pop, fifo_wr, drop;
  logic [CNT_W-1:0]  bin_cnt_reg, cnt_plus;
  logic [TS_W-1:0]   ts_reg;
  logic              half_sel_reg, overflow_reg, underflow_reg;
  logic [WORD_W-1:0] wr_word, rd_word;
  logic              fifo_full, fifo_empty;

  assign spike_pulse = pulse[0] & enable;
  assign sim_pulse   = pulse[1] & enable;

  // A spike arriving with the bin edge belongs to the bin being closed.
  always_comb begin
    cnt_plus = bin_cnt_reg;
    if (spike_pulse && (bin_cnt_reg != CNT_SAT)) cnt_plus = bin_cnt_reg + 1'b1;
  end

  assign wr_word = {ts_reg, cnt_plus};

`ifdef SPIKE_BIN_SKIP_EMPTY_EN
  assign bin_wanted = sim_pulse && (cnt_plus != '0);
`else
  assign bin_wanted = sim_pulse;
`endif

  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign pop     = pipe.pipe_read && !fifo_empty && half_sel_reg && !clear;
  assign fifo_wr = bin_wanted && (!fifo_full || pop) && !clear;
  assign drop    = bin_wanted && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt_reg   <= '0;
      ts_reg        <= '0;
      half_sel_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clear) begin
      bin_cnt_reg   <= '0;
      ts_reg        <= '0;
      half_sel_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (sim_pulse) begin
        bin_cnt_reg <= '0;
        ts_reg      <= ts_reg + 1'b1;
      end else begin
        bin_cnt_reg <= cnt_plus;
      end
      if (drop) overflow_reg <= 1'b1;
      if (pipe.pipe_read) begin
        if (fifo_empty) underflow_reg <= 1'b1;
        else            half_sel_reg  <= ~half_sel_reg;
      end
    end
  end

  sync_fifo_32 #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clear),
    .wr_en   (fifo_wr),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign pipe.pipe_data = fifo_empty ? '0 : half_of(rd_word, half_sel_reg);
  assign empty          = fifo_empty;
  assign full           = fifo_full;
  assign overflow       = overflow_reg;
  assign underflow      = underflow_reg;
  assign ts_now         = ts_reg;
endmodule

// File: tb/tb_spike_bin_fifo.sv
// Testbench for spike_bin_fifo. dut_a: DEPTH=4, 16/16-bit fields.
// dut_b: DEPTH=4, 8-bit count / 24-bit timestamp, so count saturation is
// reachable in a short run. Read data is checked by scoreboard monitors.
module tb_spike_bin_fifo;
  import spike_bin_pkg::*;

  logic clk, reset_n;
  logic a_spike, a_sim, a_en, a_clear;
  logic b_spike, b_sim, b_en, b_clear;
  logic [2:0]  a_level, b_level;
  logic        a_empty, a_full, a_ovf, a_unf;
  logic        b_empty, b_full, b_ovf, b_unf;
  logic [15:0] a_ts;
  logic [23:0] b_ts;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  logic [15:0] e_a, e_b;

  spike_bin_fifo_if pipe_a ();
  spike_bin_fifo_if pipe_b ();

  spike_bin_fifo #(.DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .spike_in(a_spike), .sim_clk_in(a_sim),
    .enable(a_en), .clear(a_clear), .pipe(pipe_a.slave), .fifo_level(a_level),
    .empty(a_empty), .full(a_full), .overflow(a_ovf), .underflow(a_unf), .ts_now(a_ts)
  );

  spike_bin_fifo #(.DEPTH(4), .CNT_W(8), .TS_W(24)) dut_b (
    .clk(clk), .reset_n(reset_n), .spike_in(b_spike), .sim_clk_in(b_sim),
    .enable(b_en), .clear(b_clear), .pipe(pipe_b.slave), .fifo_level(b_level),
    .empty(b_empty), .full(b_full), .overflow(b_ovf), .underflow(b_unf), .ts_now(b_ts)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: the half-word on pipe_data while pipe_read is high is the one consumed.
  always @(negedge clk) begin
    if (reset_n && pipe_a.pipe_read) begin
      n_checks++;
      if (exp_a_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_a_unexpected: got 0x%04h, no expected entry", pipe_a.pipe_data);
      end else begin
        e_a = exp_a_q.pop_front();
        if (pipe_a.pipe_data !== e_a) begin
          n_fail++;
          $display("FAIL sb_a_read: got 0x%04h, expected 0x%04h", pipe_a.pipe_data, e_a);
        end else $display("read A 0x%04h ok", pipe_a.pipe_data);
      end
    end
    if (reset_n && pipe_b.pipe_read) begin
      n_checks++;
      if (exp_b_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b_unexpected: got 0x%04h, no expected entry", pipe_b.pipe_data);
      end else begin
        e_b = exp_b_q.pop_front();
        if (pipe_b.pipe_data !== e_b) begin
          n_fail++;
          $display("FAIL sb_b_read: got 0x%04h, expected 0x%04h", pipe_b.pipe_data, e_b);
        end else $display("read B 0x%04h ok", pipe_b.pipe_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_spikes(input int n);
    for (int i = 0; i < n; i++) begin
      a_spike = 1'b1; tick(1);
      a_spike = 1'b0; tick(1);
    end
  endtask

  task automatic a_bin();
    a_sim = 1'b1; tick(1);
    a_sim = 1'b0; tick(1);
  endtask

  task automatic a_rd(input logic [15:0] e);
    exp_a_q.push_back(e);
    pipe_a.pipe_read = 1'b1; tick(1);
    pipe_a.pipe_read = 1'b0;
  endtask

  task automatic b_spikes(input int n);
    for (int i = 0; i < n; i++) begin
      b_spike = 1'b1; tick(1);
      b_spike = 1'b0; tick(1);
    end
  endtask

  task automatic b_bin();
    b_sim = 1'b1; tick(1);
    b_sim = 1'b0; tick(1);
  endtask

  task automatic b_rd(input logic [15:0] e);
    exp_b_q.push_back(e);
    pipe_b.pipe_read = 1'b1; tick(1);
    pipe_b.pipe_read = 1'b0;
  endtask

  task automatic a_clear_pulse();
    a_clear = 1'b1; tick(1);
    a_clear = 1'b0;
  endtask

  bin_word_t w;

  initial begin
    reset_n = 1'b0;
    a_spike = 0; a_sim = 0; a_en = 0; a_clear = 0;
    b_spike = 0; b_sim = 0; b_en = 0; b_clear = 0;
    pipe_a.pipe_read = 1'b0;
    pipe_b.pipe_read = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full", 32'(a_full), 32'd0);
    chk("rst_level", 32'(a_level), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_unf", 32'(a_unf), 32'd0);
    chk("rst_ts", 32'(a_ts), 32'd0);
    chk("rst_pipe_data", 32'(pipe_a.pipe_data), 32'd0);
    tick(1);
    reset_n = 1'b1;
    a_en = 1'b1;
    tick(2);

    // Bins of 3, 0 and 5 spikes
    a_spikes(3); a_bin();
    a_bin();
    a_spikes(5); a_bin();
    tick(3);
    @(negedge clk);
    chk("t1_ts", 32'(a_ts), 32'd3);
`ifdef SPIKE_BIN_SKIP_EMPTY_EN
    chk("t1_level", 32'(a_level), 32'd2);
    a_rd(16'h0003); a_rd(16'h0000);
    a_rd(16'h0005); a_rd(16'h0002);
`else
    chk("t1_level", 32'(a_level), 32'd3);
    a_rd(16'h0003); a_rd(16'h0000);
    a_rd(16'h0000); a_rd(16'h0001);
    a_rd(16'h0005); a_rd(16'h0002);
`endif
    @(negedge clk);
    chk("t1_empty", 32'(a_empty), 32'd1);

    // Spike coinciding with the bin edge is counted in the closing bin
    a_spikes(2);
    a_spike = 1'b1; a_sim = 1'b1; tick(1);
    a_spike = 1'b0; a_sim = 1'b0; tick(1);
    a_spikes(1); a_bin();
    tick(3);
    @(negedge clk);
    chk("t4_level", 32'(a_level), 32'd2);
    chk("t4_ts", 32'(a_ts), 32'd5);
    a_rd(16'h0003); a_rd(16'h0003);
    a_rd(16'h0001); a_rd(16'h0004);

    // enable=0: spikes and bin edges ignored
    a_en = 1'b0;
    a_spikes(2); a_bin();
    tick(3);
    @(negedge clk);
    chk("en0_ts", 32'(a_ts), 32'd5);
    chk("en0_level", 32'(a_level), 32'd0);
    a_en = 1'b1;
    tick(1);

    // Count saturation (8-bit count instance)
    b_en = 1'b1;
    b_spikes(300); b_bin();
    b_spikes(2);   b_bin();
    tick(3);
    @(negedge clk);
    chk("t2_level", 32'(b_level), 32'd2);
    chk("t2_ts", 32'(b_ts), 32'd2);
    b_rd(16'h00FF); b_rd(16'h0000);
    b_rd(16'h0102); b_rd(16'h0000);

    // Overflow with DEPTH=4, then drain and underflow
    a_clear_pulse();
    @(negedge clk);
    chk("t3_clr_ts", 32'(a_ts), 32'd0);
    for (int i = 0; i < 6; i++) begin
      a_spikes(1); a_bin();
    end
    tick(3);
    @(negedge clk);
    chk("t3_level", 32'(a_level), 32'd4);
    chk("t3_full", 32'(a_full), 32'd1);
    chk("t3_ovf", 32'(a_ovf), 32'd1);
    chk("t3_ts", 32'(a_ts), 32'd6);
    for (int i = 0; i < 4; i++) begin
      w.ts = 16'(i); w.cnt = 16'd1;
      a_rd(w[15:0]); a_rd(w[31:16]);
    end
    @(negedge clk);
    chk("t3_empty", 32'(a_empty), 32'd1);
    chk("t3_unf_pre", 32'(a_unf), 32'd0);
    a_rd(16'h0000);
    @(negedge clk);
    chk("t3_unf", 32'(a_unf), 32'd1);
    chk("t3_level_after", 32'(a_level), 32'd0);

    // clear with 3 words queued and both sticky flags set
    for (int i = 0; i < 3; i++) begin
      a_spikes(1); a_bin();
    end
    tick(3);
    @(negedge clk);
    chk("t6_level", 32'(a_level), 32'd3);
    chk("t6_flags", {30'd0, a_ovf, a_unf}, 32'd3);
    chk("t6_ts", 32'(a_ts), 32'd9);
    tick(1);
    a_clear_pulse();
    @(negedge clk);
    chk("t6_empty", 32'(a_empty), 32'd1);
    chk("t6_clr_level", 32'(a_level), 32'd0);
    chk("t6_clr_ts", 32'(a_ts), 32'd0);
    chk("t6_clr_flags", {30'd0, a_ovf, a_unf}, 32'd0);
    chk("t6_clr_data", 32'(pipe_a.pipe_data), 32'd0);

    // Pop of the high half coinciding with a write while full
    for (int i = 0; i < 4; i++) begin
      a_spikes(1); a_bin();
    end
    tick(3);
    @(negedge clk);
    chk("t5_full", 32'(a_full), 32'd1);
    tick(1);
    a_rd(16'h0001);
    a_spike = 1'b1; a_sim = 1'b1; tick(1);
    a_spike = 1'b0; a_sim = 1'b0; tick(1);
    exp_a_q.push_back(16'h0000);
    pipe_a.pipe_read = 1'b1; tick(1);
    pipe_a.pipe_read = 1'b0;
    @(negedge clk);
    chk("t5_level", 32'(a_level), 32'd4);
    chk("t5_ovf", 32'(a_ovf), 32'd0);
    chk("t5_ts", 32'(a_ts), 32'd5);
    for (int i = 1; i < 5; i++) begin
      w.ts = 16'(i); w.cnt = 16'd1;
      a_rd(w[15:0]); a_rd(w[31:16]);
    end

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) begin
      a_spikes(1); a_bin();
    end
    tick(3);
    @(negedge clk);
    chk("rst2_pre_ovf", 32'(a_ovf), 32'd1);
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst2_level", 32'(a_level), 32'd0);
    chk("rst2_empty", 32'(a_empty), 32'd1);
    chk("rst2_ovf", 32'(a_ovf), 32'd0);
    chk("rst2_ts", 32'(a_ts), 32'd0);
    chk("rst2_data", 32'(pipe_a.pipe_data), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(2);

    // Zero-count bins
    a_bin(); a_bin();
    tick(3);
    @(negedge clk);
    chk("zb_ts", 32'(a_ts), 32'd2);
`ifdef SPIKE_BIN_SKIP_EMPTY_EN
    chk("zb_level", 32'(a_level), 32'd0);
`else
    chk("zb_level", 32'(a_level), 32'd2);
    a_rd(16'h0000); a_rd(16'h0000);
    a_rd(16'h0000); a_rd(16'h0001);
`endif

    tick(2);
    chk("sb_a_drained", 32'(exp_a_q.size()), 32'd0);
    chk("sb_b_drained", 32'(exp_b_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
